// File: rtl/maze_path_checker_if.sv
// Bundled host and solver signals of maze_path_checker.
// The DUT sits on the slave modport; a host/solver model drives the master side.
interface maze_path_checker_if #(
  parameter int MAZE_SIZE = 17
);
  // Both serial streams are valid-only: a beat transfers on every rising clk edge
  // where its valid is high; there is no ready and no backpressure in either direction.
  logic                 ld_en;
  logic [4:0]           ld_row;
  logic [MAZE_SIZE-1:0] ld_data;
  logic                 start;
  logic                 maze_in_valid;
  logic                 maze_in;
  logic                 path_out_valid;
  logic [1:0]           path_out;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2:0]           err_code;
  logic [8:0]           step_cnt;
  logic [4:0]           state_dbg;

  modport master (
    output ld_en, ld_row, ld_data, start, path_out_valid, path_out,
    input  maze_in_valid, maze_in, busy, done, pass, err_code, step_cnt, state_dbg
  );

  modport slave (
    input  ld_en, ld_row, ld_data, start, path_out_valid, path_out,
    output maze_in_valid, maze_in, busy, done, pass, err_code, step_cnt, state_dbg
  );
endinterface

// File: rtl/maze_path_checker.sv
// Streams a stored maze to an external solver, then walks the returned direction
// symbols from (0,0) and reports whether they reach the far corner legally.
module maze_path_checker #(
  parameter int MAZE_SIZE = 17,
  parameter int TIMEOUT   = 4095,
  parameter int MAX_STEPS = 288
) (
  input logic                clk,
  input logic                rst,
  maze_path_checker_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    SEND   = 5'b00010,
    WAIT   = 5'b00100,
    CHECK  = 5'b01000,
    REPORT = 5'b10000
  } state_t;

  localparam int                TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [4:0]        LAST    = 5'(MAZE_SIZE - 1);
  localparam logic [5:0]        ROWS    = 6'(MAZE_SIZE);
  localparam logic signed [5:0] LAST_S  = 6'(MAZE_SIZE - 1);
  localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0]        MAX_S   = 9'(MAX_STEPS);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_OOB     = 3'd1;
  localparam logic [2:0] ERR_WALL    = 3'd2;
  localparam logic [2:0] ERR_STEPS   = 3'd3;
  localparam logic [2:0] ERR_NO_END  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_PROTO   = 3'd6;

  state_t               state_q, state_d;
  logic [MAZE_SIZE-1:0] maze_q [MAZE_SIZE];
  logic [4:0]           row_q, row_d, col_q, col_d;
  logic [4:0]           py_q, py_d, px_q, px_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [2:0]           err_q, err_d;
  logic [8:0]           step_q, step_d;
  logic                 pass_q, pass_d;

  logic [8:0]        step_inc;
  logic signed [5:0] ny, nx;
  logic              oob, wall, take_sym;
  logic [2:0]        sym_err;

  // Maze rows are only writable while idle, so a run always sees a stable maze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAZE_SIZE; i++) maze_q[i] <= '0;
    end else if (state_q == IDLE && bus.ld_en && ({1'b0, bus.ld_row} < ROWS)) begin
      maze_q[bus.ld_row] <= bus.ld_data;
    end
  end

  // Next coordinates are one bit wider and signed so steps off either edge stay visible.
  always_comb begin
    step_inc = (step_q == 9'h1FF) ? step_q : step_q + 9'd1;
    ny = $signed({1'b0, py_q});
    nx = $signed({1'b0, px_q});
    case (bus.path_out)
      2'd0:    nx = nx + 6'sd1;
      2'd1:    ny = ny + 6'sd1;
      2'd2:    nx = nx - 6'sd1;
      default: ny = ny - 6'sd1;
    endcase
    oob  = (ny < 6'sd0) || (nx < 6'sd0) || (ny > LAST_S) || (nx > LAST_S);
    wall = !oob && !maze_q[ny[4:0]][nx[4:0]];
    if (step_inc > MAX_S)  sym_err = ERR_STEPS;
    else if (oob)          sym_err = ERR_OOB;
    else if (wall)         sym_err = ERR_WALL;
    else                   sym_err = ERR_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      py_q    <= '0;
      px_q    <= '0;
      tcnt_q  <= '0;
      err_q   <= '0;
      step_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      py_q    <= py_d;
      px_q    <= px_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    py_d     = py_q;
    px_d     = px_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    step_d   = step_q;
    pass_d   = pass_q;
    take_sym = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SEND;
          row_d   = '0;
          col_d   = '0;
          py_d    = '0;
          px_d    = '0;
          err_d   = ERR_NONE;
          step_d  = '0;
          pass_d  = 1'b0;
        end
      end
      SEND: begin
        // A symbol arriving before the maze is fully sent is flagged, never walked.
        if (bus.path_out_valid && err_q == ERR_NONE) err_d = ERR_PROTO;
        if (col_q == LAST) begin
          col_d = '0;
          if (row_q == LAST) begin
            row_d   = '0;
            tcnt_d  = '0;
            state_d = WAIT;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      WAIT: begin
        if (bus.path_out_valid) begin
          take_sym = 1'b1;
          state_d  = CHECK;
        end else if (tcnt_q == TO_LAST) begin
          state_d = REPORT;
          if (err_q == ERR_NONE) err_d = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      CHECK: begin
        if (bus.path_out_valid) begin
          take_sym = 1'b1;
        end else begin
          state_d = REPORT;
          if (err_q == ERR_NONE && !(py_q == LAST && px_q == LAST)) err_d = ERR_NO_END;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // After the first error the walker freezes but keeps counting symbols.
    if (take_sym) begin
      step_d = step_inc;
      if (err_q == ERR_NONE) begin
        if (sym_err != ERR_NONE) begin
          err_d = sym_err;
        end else begin
          py_d = ny[4:0];
          px_d = nx[4:0];
        end
      end
    end

    if (state_d == REPORT && state_q != REPORT) pass_d = (err_d == ERR_NONE);
  end

  assign bus.maze_in_valid = (state_q == SEND);
  assign bus.maze_in       = (state_q == SEND) ? maze_q[row_q][col_q] : 1'b0;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == REPORT);
  assign bus.pass          = pass_q;
  assign bus.err_code      = err_q;
  assign bus.step_cnt      = step_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_maze_path_checker.sv
// Directed runs of maze_path_checker against hand-computed verdicts; a negedge
// monitor scores every done pulse, the serial maze stream and reset behaviour.
module tb_maze_path_checker;

  localparam int MS    = 17;
  localparam int NBITS = MS * MS;
  localparam int TO    = 4095;
  localparam int EW    = 35;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maze_path_checker_if #(.MAZE_SIZE(MS)) bus ();

  maze_path_checker #(
    .MAZE_SIZE(MS),
    .TIMEOUT  (TO),
    .MAX_STEPS(288)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Expected entry: {pass, err_code[2:0], step_cnt[8:0], maze_bits[8:0], wait_cycles[12:0]}
  logic [EW-1:0] exp_q[$];
  logic [MS-1:0] tb_maze [MS];
  logic [1:0]    sym_buf [512];
  int            nsym = 0;
  int            checks = 0;
  int            failures = 0;

  function automatic logic [EW-1:0] mk_exp(input logic p, input logic [2:0] e,
                                           input logic [8:0] s, input logic [8:0] b,
                                           input logic [12:0] w);
    return {p, e, s, b, w};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int            bit_cnt = 0;
  int            stream_err = 0;
  int            wait_cnt = 0;
  logic          held_valid = 1'b0;
  logic [12:0]   held = '0;
  logic [EW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", 32'({bus.maze_in_valid, bus.maze_in, bus.busy, bus.done,
                              bus.pass, bus.err_code, bus.step_cnt}), 32'd0);
      chk("rst_state_idle", 32'(bus.state_dbg), 32'd1);
      bit_cnt    = 0;
      stream_err = 0;
      wait_cnt   = 0;
      held_valid = 1'b0;
    end else begin
      if (bus.maze_in_valid) begin
        if (bit_cnt < NBITS && bus.maze_in !== tb_maze[bit_cnt / MS][bit_cnt % MS])
          stream_err++;
        bit_cnt++;
      end else if (bus.maze_in !== 1'b0) begin
        stream_err++;
      end
      if (bus.busy && !bus.maze_in_valid && !bus.done) wait_cnt++;

      if (bus.done) begin
        chk("done_has_pending_run", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("pass",        32'(bus.pass),     32'(mon_e[34]));
          chk("err_code",    32'(bus.err_code), 32'(mon_e[33:31]));
          chk("step_cnt",    32'(bus.step_cnt), 32'(mon_e[30:22]));
          chk("maze_bits",   32'(bit_cnt),      32'(mon_e[21:13]));
          chk("maze_stream", 32'(stream_err),   32'd0);
          if (mon_e[12:0] != 13'd0) chk("wait_cycles", 32'(wait_cnt), 32'(mon_e[12:0]));
          held       = mon_e[34:22];
          held_valid = 1'b1;
        end else begin
          held_valid = 1'b0;
        end
        bit_cnt    = 0;
        stream_err = 0;
        wait_cnt   = 0;
      end else if (bus.busy) begin
        held_valid = 1'b0;
      end else if (held_valid) begin
        chk("result_held", 32'({bus.pass, bus.err_code, bus.step_cnt}), 32'(held));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic add_syms(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sym_buf[nsym] = d;
      nsym++;
    end
  endtask

  task automatic load_corridor();
    logic [MS-1:0] row_v;
    for (int r = 0; r < MS; r++) begin
      row_v = '0;
      if (r == 0) row_v = '1;
      else        row_v[MS-1] = 1'b1;
      @(negedge clk);
      bus.ld_en   = 1'b1;
      bus.ld_row  = 5'(r);
      bus.ld_data = row_v;
      tb_maze[r]  = row_v;
    end
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  // glitch_at: SEND cycle with a stray path_out_valid; restart_at: SEND cycle with a
  // stray start and ld_en (plus a second start 150 cycles later); -1 disables each.
  task automatic do_run(input int glitch_at, input int restart_at, input logic [EW-1:0] e);
    int cyc;
    int k;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.maze_in_valid && cyc < 400) begin
      bus.path_out_valid = (cyc == glitch_at);
      bus.start   = (restart_at >= 0) && (cyc == restart_at || cyc == restart_at + 150);
      bus.ld_en   = (restart_at >= 0) && (cyc == restart_at);
      bus.ld_row  = 5'd0;
      bus.ld_data = '0;
      @(negedge clk);
      cyc++;
    end
    bus.path_out_valid = 1'b0;
    bus.start          = 1'b0;
    bus.ld_en          = 1'b0;
    for (int i = 0; i < nsym; i++) begin
      bus.path_out_valid = 1'b1;
      bus.path_out       = sym_buf[i];
      @(negedge clk);
    end
    bus.path_out_valid = 1'b0;
    k = 0;
    while (!bus.done && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      $display("FAIL run_done_timeout actual=no_done required=done_within_%0d_cycles", TO + 100);
      $fatal(1, "run stalled");
    end
    @(negedge clk);
    nsym = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ld_en          = 1'b0;
    bus.ld_row         = '0;
    bus.ld_data        = '0;
    bus.start          = 1'b0;
    bus.path_out_valid = 1'b0;
    bus.path_out       = '0;
    for (int i = 0; i < MS; i++) tb_maze[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    load_corridor();

    // good corridor path
    add_syms(2'd0, 16); add_syms(2'd1, 16);
    do_run(-1, -1, mk_exp(1'b1, 3'd0, 9'd32, 9'd289, 13'd0));

    // UP at y=0 first, remainder still counted
    add_syms(2'd3, 1); add_syms(2'd0, 16); add_syms(2'd1, 16);
    do_run(-1, -1, mk_exp(1'b0, 3'd1, 9'd33, 9'd289, 13'd0));

    // DOWN into the wall at (1,1)
    add_syms(2'd0, 1); add_syms(2'd1, 1); add_syms(2'd0, 2);
    do_run(-1, -1, mk_exp(1'b0, 3'd2, 9'd4, 9'd289, 13'd0));

    // LEFT at x=0
    add_syms(2'd2, 1); add_syms(2'd0, 1);
    do_run(-1, -1, mk_exp(1'b0, 3'd1, 9'd2, 9'd289, 13'd0));

    // partial path, end not reached
    add_syms(2'd0, 10);
    do_run(-1, -1, mk_exp(1'b0, 3'd4, 9'd10, 9'd289, 13'd0));

    // solver never answers
    do_run(-1, -1, mk_exp(1'b0, 3'd5, 9'd0, 9'd289, 13'(TO)));

    // stray symbol during SEND, then an otherwise good path
    add_syms(2'd0, 16); add_syms(2'd1, 16);
    do_run(100, -1, mk_exp(1'b0, 3'd6, 9'd32, 9'd289, 13'd0));

    // start and ld_en while busy are ignored
    add_syms(2'd0, 16); add_syms(2'd1, 16);
    do_run(-1, 5, mk_exp(1'b1, 3'd0, 9'd32, 9'd289, 13'd0));

    // 289 legal RIGHT/LEFT moves: the 289th exceeds MAX_STEPS
    for (int i = 0; i < 289; i++) add_syms((i % 2 == 0) ? 2'd0 : 2'd2, 1);
    do_run(-1, -1, mk_exp(1'b0, 3'd3, 9'd289, 9'd289, 13'd0));

    // reset mid-SEND aborts the run and clears the maze
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < MS; i++) tb_maze[i] = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // cleared maze: all-zero stream, first step hits a wall
    add_syms(2'd0, 1);
    do_run(-1, -1, mk_exp(1'b0, 3'd2, 9'd1, 9'd289, 13'd0));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
